// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner: banked anode/cathode drive with anti-ghost guard,
// PWM brightness and frame-synchronous display update.
module sevenseg_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int BANK_DIGITS = 4,
    parameter int DIGIT_TICKS = 100000,
    parameter int GUARD_TICKS = 64,
    parameter int BRIGHT_W    = 4
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  enable,
    input  logic                                  load,
    input  logic [4*NUM_DIGITS-1:0]               digit_data,
    input  logic [NUM_DIGITS-1:0]                 dp_in,
    input  logic [NUM_DIGITS-1:0]                 blank,
    input  logic [BRIGHT_W-1:0]                   brightness,
    output logic [NUM_DIGITS-1:0]                 an,
    output logic [7*(NUM_DIGITS/BANK_DIGITS)-1:0] seg,
    output logic [(NUM_DIGITS/BANK_DIGITS)-1:0]   dp,
    output logic                                  frame_done
);

    localparam int NUM_BANKS = NUM_DIGITS / BANK_DIGITS;
    localparam int TICK_W    = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int SCAN_W    = (BANK_DIGITS > 1) ? $clog2(BANK_DIGITS) : 1;

    generate
        if ((NUM_DIGITS % BANK_DIGITS) != 0 || GUARD_TICKS >= DIGIT_TICKS) begin : g_param_check
            $error("sevenseg_scan: NUM_DIGITS must be a multiple of BANK_DIGITS and GUARD_TICKS < DIGIT_TICKS");
        end
    endgenerate

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] data;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blank;
    } frame_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    logic [TICK_W-1:0]      r_tick_cnt;
    logic [SCAN_W-1:0]      r_scan_idx;
    logic [BRIGHT_W-1:0]    r_pwm_cnt;
    frame_t                 r_pend;
    frame_t                 r_disp;
    logic [NUM_DIGITS-1:0]  r_an;
    logic [7*NUM_BANKS-1:0] r_seg;
    logic [NUM_BANKS-1:0]   r_dp;
    logic                   r_frame_done;

    logic                   w_tick_last;
    logic                   w_scan_last;
    logic                   w_wrap;
    logic                   w_an_on;
    logic [NUM_DIGITS-1:0]  w_an_next;
    logic [7*NUM_BANKS-1:0] w_seg_next;
    logic [NUM_BANKS-1:0]   w_dp_next;

    assign w_tick_last = (r_tick_cnt == TICK_W'(DIGIT_TICKS - 1));
    assign w_scan_last = (r_scan_idx == SCAN_W'(BANK_DIGITS - 1));
    assign w_wrap      = w_tick_last && w_scan_last;

    // Anodes stay off during the guard window so the cathodes settle before light-up.
    assign w_an_on = (r_tick_cnt >= TICK_W'(GUARD_TICKS)) &&
                     ((r_pwm_cnt < brightness) || (&brightness));

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [BANK_DIGITS-1:0][3:0] w_nib;
        logic [BANK_DIGITS-1:0]      w_dp_bits;
        logic [BANK_DIGITS-1:0]      w_blank_bits;

        assign w_nib        = r_disp.data[b*BANK_DIGITS +: BANK_DIGITS];
        assign w_dp_bits    = r_disp.dp[b*BANK_DIGITS +: BANK_DIGITS];
        assign w_blank_bits = r_disp.blank[b*BANK_DIGITS +: BANK_DIGITS];

        assign w_seg_next[7*b +: 7] = w_blank_bits[r_scan_idx] ? 7'h7F
                                                               : hex_to_seg(w_nib[r_scan_idx]);
        assign w_dp_next[b] = w_blank_bits[r_scan_idx] | ~w_dp_bits[r_scan_idx];

        for (genvar k = 0; k < BANK_DIGITS; k++) begin : g_digit
            assign w_an_next[b*BANK_DIGITS + k] = ~(w_an_on && (r_scan_idx == SCAN_W'(k)));
        end
    end

    // NOTE: every register here uses <= so all updates see the pre-edge state; this is
    // what makes a load on the wrap cycle commit the older pending value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt   <= '0;
            r_scan_idx   <= '0;
            r_pwm_cnt    <= '0;
            r_pend       <= '0;
            r_disp       <= '0;
            r_an         <= '1;
            r_seg        <= '1;
            r_dp         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + BRIGHT_W'(1);
            r_seg     <= w_seg_next;
            r_dp      <= w_dp_next;
            if (load) begin
                r_pend <= '{data: digit_data, dp: dp_in, blank: blank};
            end
            if (!enable) begin
                r_tick_cnt   <= '0;
                r_scan_idx   <= '0;
                r_an         <= '1;
                r_frame_done <= 1'b0;
                r_disp       <= r_pend;
            end else begin
                r_an         <= w_an_next;
                r_frame_done <= w_wrap;
                if (w_wrap) begin
                    r_disp <= r_pend;
                end
                if (w_tick_last) begin
                    r_tick_cnt <= '0;
                    r_scan_idx <= w_scan_last ? '0 : r_scan_idx + SCAN_W'(1);
                end else begin
                    r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                end
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
